hack_rom_loader: RTL

//  Serial boot loader for the Hack Computer: the write side of the instruction ROM that the CPU reads.
//  - Consumes a byte stream over a valid/ready handshake and writes 16-bit words into the ROM write port.
//  - Holds the Computer in reset until a complete image has been written and its checksum verified.
//  - Replaces load-by-file in silicon-style flows.

---
 rtl/hack_rom_loader_pkg.sv | 23 ++
 rtl/hack_rom_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader_pkg.sv
// rtl/hack_rom_loader_pkg.sv - shared widths and FSM encoding for the Hack ROM boot loader
package hack_rom_loader_pkg;

    localparam int ROM_ADDR_W  = 15;
    localparam int HACK_WORD_W = 16;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    function automatic logic is_rx_state(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DAT_HI) ||
               (s == ST_DAT_LO) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - byte-stream boot loader writing the Hack instruction ROM
module hack_rom_loader
    import hack_rom_loader_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int MAX_WORDS = 32768
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    input  logic                   start_i,
    output logic                   rom_we_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    output logic [HACK_WORD_W-1:0] rom_wdata_o,
    output logic                   cpu_reset_o,
    output logic                   done_o,
    output logic                   error_o
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_e                   state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [7:0]               sum_q, sum_d;
    logic [7:0]               hi_q, hi_d;
    logic                     rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [HACK_WORD_W-1:0]   rom_wdata_q, rom_wdata_d;
    logic                     rx_ready_q, cpu_reset_q, done_q, error_q;

    logic                     accept;
    logic [7:0]               byte_sum;
    logic [15:0]              pair_word;
    logic [15:0]              cnt_inc;

    assign accept    = rx_valid_i & rx_ready_q;
    assign byte_sum  = sum_q + rx_data_i;
    assign pair_word = {hi_q, rx_data_i};
    assign cnt_inc   = cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        // Address advances in the cycle the write strobe is visible, so the strobe sees the old address.
        if (rom_we_q) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_INIT: state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (accept) begin
                    hi_d    = rx_data_i;
                    sum_d   = byte_sum;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    sum_d = byte_sum;
                    len_d = pair_word;
                    cnt_d = 16'd0;
                    if ({1'b0, pair_word} > MAX_LEN) begin
                        state_d = ST_ERR;
                    end else if (pair_word == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (accept) begin
                    hi_d    = rx_data_i;
                    sum_d   = byte_sum;
                    state_d = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (accept) begin
                    sum_d       = byte_sum;
                    rom_we_d    = 1'b1;
                    rom_wdata_d = pair_word;
                    cnt_d       = cnt_inc;
                    state_d     = (cnt_inc == len_q) ? ST_CSUM : ST_DAT_HI;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    sum_d   = byte_sum;
                    state_d = (byte_sum == 8'h00) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_LEN_HI;
                    rom_addr_d = '0;
                    sum_d      = 8'h00;
                    cnt_d      = 16'd0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_INIT;
            len_q       <= 16'd0;
            cnt_q       <= 16'd0;
            sum_q       <= 8'h00;
            hi_q        <= 8'h00;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            rx_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            // Status flags are decoded from the next state so they stay registered yet track the FSM.
            rx_ready_q  <= is_rx_state(state_d);
            cpu_reset_q <= (state_d != ST_DONE);
            done_q      <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERR);
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign rom_we_o    = rom_we_q;
    assign rom_addr_o  = rom_addr_q;
    assign rom_wdata_o = rom_wdata_q;
    assign cpu_reset_o = cpu_reset_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule
